// File: rtl/aidc_code_packer.sv
// aidc_code_packer: packs MSB-aligned variable-length code fragments, behind a
// configurable prefix, into WORD_W-bit words with a per-block word address.
module aidc_code_packer #(
  parameter int unsigned DATA_SIZE = 66,
  parameter int unsigned SIZE_W    = 7,
  parameter int unsigned WORD_W    = 64,
  parameter int unsigned MAX_WORDS = 8,
  parameter int unsigned PREFIX_W  = 2,
  parameter logic [PREFIX_W-1:0] PREFIX = 2'b00,
  parameter int unsigned BITS_W    = 16,
  localparam int unsigned ADDR_W   = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 sop_i,
  input  logic                 eop_i,
  input  logic [DATA_SIZE-1:0] data_i,
  input  logic [SIZE_W-1:0]    size_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [ADDR_W-1:0]    addr_o,
  output logic [WORD_W-1:0]    data_o,
  output logic                 last_o,
  output logic                 done_o,
  output logic                 fail_o,
  output logic [BITS_W-1:0]    blk_bits_o
);

  localparam int unsigned ACC_W = WORD_W - 1 + DATA_SIZE;
  localparam int unsigned CNT_W = $clog2(ACC_W + 1);
  localparam int unsigned WC_W  = $clog2(MAX_WORDS + 1);
  localparam int unsigned PAD_W = ACC_W - DATA_SIZE;
  localparam int unsigned TOT_X = BITS_W + 1;
  localparam int unsigned CAP   = MAX_WORDS * WORD_W;

  localparam logic [ACC_W-1:0]     PRE_ACC  = {PREFIX, {(ACC_W-PREFIX_W){1'b0}}};
  localparam logic [DATA_SIZE-1:0] ONES     = '1;
  localparam logic [CNT_W-1:0]     WORD_CNT = CNT_W'(WORD_W);

  typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_e;

  state_e              state_q;
  logic [ACC_W-1:0]    acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [WC_W-1:0]     wcnt_q;
  logic [BITS_W-1:0]   tot_q;
  logic                eop_q;
  logic                ready_q, valid_q, last_q, done_q, fail_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   data_q;
  logic [BITS_W-1:0]   bits_q;

  logic [DATA_SIZE-1:0] mask_c;
  logic [ACC_W-1:0]     ext_c, base_acc, app_acc, w_acc;
  logic [CNT_W-1:0]     base_cnt, app_cnt, w_cnt, rem_cnt;
  logic [BITS_W-1:0]    base_tot, app_tot, w_tot;
  logic [TOT_X-1:0]     tot_sum;
  logic [WC_W-1:0]      w_wcnt;
  logic                 w_eop, accept_c, active_c, can_load_c;
  logic                 w_full_c, emit_c, final_c, ovf_c;

  // Append the masked fragment behind the current (or freshly preloaded) bits
  always_comb begin
    mask_c   = ~(ONES >> size_i);
    ext_c    = {data_i & mask_c, {PAD_W{1'b0}}};
    base_acc = sop_i ? PRE_ACC : acc_q;
    base_cnt = sop_i ? CNT_W'(PREFIX_W) : cnt_q;
    base_tot = sop_i ? BITS_W'(PREFIX_W) : tot_q;
    app_acc  = base_acc | (ext_c >> base_cnt);
    app_cnt  = base_cnt + CNT_W'(size_i);
    tot_sum  = TOT_X'(base_tot) + TOT_X'(size_i);
    app_tot  = tot_sum[BITS_W] ? '1 : tot_sum[BITS_W-1:0];
  end

  // Working view: the just-appended beat lets a word leave in the same edge
  always_comb begin
    accept_c   = valid_i & ready_q;
    w_acc      = accept_c ? app_acc : acc_q;
    w_cnt      = accept_c ? app_cnt : cnt_q;
    w_tot      = accept_c ? app_tot : tot_q;
    w_eop      = accept_c ? eop_i   : eop_q;
    w_wcnt     = (accept_c && sop_i) ? '0 : wcnt_q;
    active_c   = accept_c | (state_q == DRAIN);
    can_load_c = ~valid_q | ready_i;
    w_full_c   = (w_cnt >= WORD_CNT);
    emit_c     = active_c & can_load_c & (w_full_c | w_eop) & (w_cnt != '0);
    final_c    = w_eop & (w_cnt <= WORD_CNT);
    rem_cnt    = w_full_c ? (w_cnt - WORD_CNT) : '0;
    ovf_c      = (32'(w_tot) > CAP);
  end

  // Block FSM, accumulator and registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= PRE_ACC;
      cnt_q   <= CNT_W'(PREFIX_W);
      wcnt_q  <= '0;
      tot_q   <= BITS_W'(PREFIX_W);
      eop_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b1;
      fail_q  <= 1'b0;
      bits_q  <= '0;
    end else begin
      if (valid_q && ready_i) valid_q <= 1'b0;
      case (state_q)
        ACCUM, DRAIN: begin
          if (active_c) begin
            acc_q  <= w_acc;
            cnt_q  <= w_cnt;
            tot_q  <= w_tot;
            eop_q  <= w_eop;
            wcnt_q <= w_wcnt;
            if (accept_c && sop_i) begin
              done_q <= 1'b0;
              fail_q <= 1'b0;
            end
            if (w_eop && (w_cnt == '0)) begin
              state_q <= DONE;
              ready_q <= 1'b0;
            end else if (emit_c) begin
              if (w_wcnt < WC_W'(MAX_WORDS)) begin
                valid_q <= 1'b1;
                data_q  <= w_acc[ACC_W-1 -: WORD_W];
                addr_q  <= ADDR_W'(w_wcnt);
                last_q  <= final_c & ~ovf_c;
                wcnt_q  <= w_wcnt + WC_W'(1);
              end
              acc_q <= w_acc << WORD_W;
              cnt_q <= rem_cnt;
              if (final_c) begin
                state_q <= DONE;
                ready_q <= 1'b0;
              end else if ((rem_cnt < WORD_CNT) && !w_eop) begin
                state_q <= ACCUM;
                ready_q <= 1'b1;
              end else begin
                state_q <= DRAIN;
                ready_q <= 1'b0;
              end
            end else if (w_full_c || w_eop) begin
              state_q <= DRAIN;
              ready_q <= 1'b0;
            end else begin
              state_q <= ACCUM;
              ready_q <= 1'b1;
            end
          end
        end
        DONE: begin
          // Wait until the final word has been handed off, then publish status
          if (can_load_c) begin
            done_q  <= 1'b1;
            fail_q  <= ovf_c;
            bits_q  <= tot_q;
            acc_q   <= PRE_ACC;
            cnt_q   <= CNT_W'(PREFIX_W);
            tot_q   <= BITS_W'(PREFIX_W);
            wcnt_q  <= '0;
            eop_q   <= 1'b0;
            state_q <= ACCUM;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ACCUM;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o    = ready_q;
  assign valid_o    = valid_q;
  assign addr_o     = addr_q;
  assign data_o     = data_q;
  assign last_o     = last_q;
  assign done_o     = done_q;
  assign fail_o     = fail_q;
  assign blk_bits_o = bits_q;

endmodule

// File: tb/tb_aidc_code_packer.sv
// Bench for aidc_code_packer: directed and random blocks checked against a
// bit-queue reference model of the packed stream.
module tb_aidc_code_packer;

  localparam int unsigned DATA_SIZE = 66;
  localparam int unsigned SIZE_W    = 7;
  localparam int unsigned WORD_W    = 64;
  localparam int unsigned MAX_WORDS = 8;
  localparam int unsigned PREFIX_W  = 2;
  localparam int unsigned BITS_W    = 16;
  localparam int unsigned ADDR_W    = 3;
  localparam logic [PREFIX_W-1:0] PREFIX = 2'b10;

  logic                 clk, rst_n;
  logic                 valid_i, ready_o, sop_i, eop_i;
  logic [DATA_SIZE-1:0] data_i;
  logic [SIZE_W-1:0]    size_i;
  logic                 valid_o, ready_i, last_o, done_o, fail_o;
  logic [ADDR_W-1:0]    addr_o;
  logic [WORD_W-1:0]    data_o;
  logic [BITS_W-1:0]    blk_bits_o;

  aidc_code_packer #(
    .DATA_SIZE(DATA_SIZE), .SIZE_W(SIZE_W), .WORD_W(WORD_W), .MAX_WORDS(MAX_WORDS),
    .PREFIX_W(PREFIX_W), .PREFIX(PREFIX), .BITS_W(BITS_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .sop_i(sop_i), .eop_i(eop_i), .data_i(data_i), .size_i(size_i),
    .valid_o(valid_o), .ready_i(ready_i), .addr_o(addr_o), .data_o(data_o),
    .last_o(last_o), .done_o(done_o), .fail_o(fail_o), .blk_bits_o(blk_bits_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WORD_W-1:0] d;
    logic [ADDR_W-1:0] a;
    logic              l;
  } word_t;

  int n_vec = 0;
  int n_err = 0;

  word_t got_q[$];
  word_t exp_q[$];
  logic [DATA_SIZE-1:0] bd[$];
  int bs[$];
  int plan_s[$];

  int rdy_mode = 1;
  int hold = 0;
  bit bp_used = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_SIZE-1:0] rand66();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[DATA_SIZE-1:0];
  endfunction

  // Reference: concatenate prefix and fragment bits, cut into words
  function automatic int model_block(input bit complete);
    bit bits[$];
    int total, nw;
    word_t w;
    for (int k = PREFIX_W - 1; k >= 0; k--) bits.push_back(PREFIX[k]);
    for (int b = 0; b < bd.size(); b++)
      for (int k = 0; k < bs[b]; k++) bits.push_back(bd[b][DATA_SIZE-1-k]);
    total = bits.size();
    nw = complete ? (total + WORD_W - 1) / WORD_W : total / WORD_W;
    for (int i = 0; i < nw && i < MAX_WORDS; i++) begin
      w.d = '0;
      for (int j = 0; j < WORD_W; j++)
        if (i * WORD_W + j < total) w.d[WORD_W-1-j] = bits[i*WORD_W+j];
      w.a = ADDR_W'(i);
      w.l = complete && (i == nw - 1) && (total <= MAX_WORDS * WORD_W);
      exp_q.push_back(w);
    end
    bd.delete();
    bs.delete();
    return total;
  endfunction

  // Consumer: drives ready_i, records handshakes, checks held words
  initial begin : consumer
    logic pv, pr, pl;
    logic [WORD_W-1:0] pd;
    logic [ADDR_W-1:0] pa;
    word_t w;
    pv = 0; pr = 0; pl = 0; pd = '0; pa = '0;
    ready_i = 1'b1;
    forever begin
      @(negedge clk);
      if (pv && !pr && rst_n) begin
        check("hold_valid", valid_o, 1);
        check("hold_data", data_o, pd);
        check("hold_addr", addr_o, pa);
        check("hold_last", last_o, pl);
      end
      case (rdy_mode)
        0: ready_i = ($urandom_range(0, 3) != 0);
        1: ready_i = 1'b1;
        2: begin
          if (hold > 0) begin
            ready_i = 1'b0;
            hold--;
          end else if (valid_o && addr_o == 1 && !bp_used) begin
            bp_used = 1;
            hold = 4;
            ready_i = 1'b0;
          end else ready_i = 1'b1;
        end
        default: ready_i = 1'b0;
      endcase
      if (valid_o && ready_i && rst_n) begin
        w.d = data_o; w.a = addr_o; w.l = last_o;
        got_q.push_back(w);
      end
      pv = valid_o; pr = ready_i; pd = data_o; pa = addr_o; pl = last_o;
    end
  end

  // Present one beat from a negedge until it is accepted
  task automatic send_beat(input bit sop, input bit eop, input int size, input logic [DATA_SIZE-1:0] d);
    int n;
    bit r;
    n = 0;
    sop_i = sop; eop_i = eop; size_i = SIZE_W'(size); data_i = d; valid_i = 1'b1;
    bd.push_back(d);
    bs.push_back(size);
    forever begin
      r = ready_o;
      @(negedge clk);
      if (r) break;
      n++;
      if (n > 2000) begin
        check("beat_accept_timeout", 0, 1);
        break;
      end
    end
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
  endtask

  task automatic compare_words(input string tag);
    int n;
    check({tag, "_nwords"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_data"}, got_q[i].d, exp_q[i].d);
      check({tag, "_addr"}, got_q[i].a, exp_q[i].a);
      check({tag, "_last"}, got_q[i].l, exp_q[i].l);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Drive the planned beats; complete blocks are checked once done_o rises
  task automatic play_block(input string tag, input bit complete, input int gap_max, input bit chk_lat);
    int total, n, waited;
    n = plan_s.size();
    for (int i = 0; i < n; i++) begin
      send_beat(i == 0, complete && (i == n - 1), plan_s[i], rand66());
      if (i == 0) check({tag, "_done_clr"}, done_o, 0);
      if (chk_lat && i == n - 1) check({tag, "_latency"}, valid_o, 1);
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
    plan_s.delete();
    total = model_block(complete);
    if (complete) begin
      waited = 0;
      while (!done_o && waited < 2000) begin
        @(negedge clk);
        waited++;
      end
      check({tag, "_done"}, done_o, 1);
      check({tag, "_fail"}, fail_o, (total > MAX_WORDS * WORD_W));
      check({tag, "_bits"}, blk_bits_o, total);
      compare_words(tag);
    end
  endtask

  task automatic plan_basic();
    plan_s = '{6, 34, 34, 34, 34, 34};
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_ready"}, ready_o, 1);
    check({tag, "_addr"}, addr_o, 0);
    check({tag, "_data"}, data_o, 0);
    check({tag, "_last"}, last_o, 0);
    check({tag, "_done"}, done_o, 1);
    check({tag, "_fail"}, fail_o, 0);
    check({tag, "_bits"}, blk_bits_o, 0);
  endtask

  initial begin : main
    int sum, nb, sz;
    rst_n = 1'b0; valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
    data_i = '0; size_i = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("reset");

    rdy_mode = 1;
    plan_basic();
    play_block("basic", 1, 0, 0);

    plan_s = '{62};
    play_block("exact", 1, 0, 1);

    plan_s = '{0};
    play_block("prefix_only", 1, 0, 1);

    rdy_mode = 2; bp_used = 0; hold = 0;
    plan_basic();
    play_block("backpressure", 1, 0, 0);
    check("bp_applied", bp_used, 1);

    rdy_mode = 1;
    for (int i = 0; i < 16; i++) plan_s.push_back(34);
    play_block("overflow", 1, 0, 0);

    plan_s = '{6, 34, 34, 34};
    play_block("abort_a", 0, 0, 0);
    plan_basic();
    play_block("abort_b", 1, 0, 0);

    rdy_mode = 0;
    for (int blk = 0; blk < 40; blk++) begin
      bit complete;
      complete = (blk == 39) || ($urandom_range(0, 9) != 0);
      nb = $urandom_range(1, 18);
      sum = PREFIX_W;
      for (int i = 0; i < nb; i++) begin
        sz = $urandom_range(0, DATA_SIZE);
        if (complete && i == nb - 1 && sz == 0 && (sum % WORD_W) == 0) sz = 1;
        plan_s.push_back(sz);
        sum += sz;
      end
      play_block("rand", complete, 2, 0);
    end

    // Park in DRAIN with the consumer stalled, then reset asynchronously
    rdy_mode = 1;
    repeat (3) @(negedge clk);
    rdy_mode = 3;
    @(negedge clk);
    send_beat(1, 0, 66, rand66());
    send_beat(0, 0, 66, rand66());
    repeat (2) @(negedge clk);
    check("drain_ready", ready_o, 0);
    check("drain_valid", valid_o, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    bd.delete(); bs.delete(); got_q.delete(); exp_q.delete();
    rdy_mode = 1;
    @(negedge clk);
    plan_basic();
    play_block("post_reset", 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
